// File: rtl/tx_frame_framer_pkg.sv
// Shared definitions for the per-port egress framer: framing constants,
// transmit FSM state encoding and the buffer entry layout.
package switch_pkg;

  localparam logic [7:0] C_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] C_SFD_BYTE      = 8'hD5;
  localparam logic [2:0] C_PREAMBLE_LEN  = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SFD  = 3'd2,
    DATA = 3'd3,
    IFG  = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic       eof;
    logic [7:0] data;
  } buf_entry_t;

endpackage

// File: rtl/tx_frame_framer_if.sv
// Crossbar-side input and GMII-side output bundle for one egress port.
// Optional statistics signals exist only when TX_FRAMER_STATS_EN is defined.
interface tx_frame_framer_if;

  logic [7:0]  tx_data_i;
  logic        tx_ctrl_i;
  logic [7:0]  gmii_txd_o;
  logic        gmii_tx_en_o;
  logic        drop_o;
  logic        busy_o;
`ifdef TX_FRAMER_STATS_EN
  logic [31:0] frames_sent_o;
  logic [31:0] frames_dropped_o;

  modport master (output tx_data_i, output tx_ctrl_i,
                  input gmii_txd_o, input gmii_tx_en_o, input drop_o, input busy_o,
                  input frames_sent_o, input frames_dropped_o);
  modport slave  (input tx_data_i, input tx_ctrl_i,
                  output gmii_txd_o, output gmii_tx_en_o, output drop_o, output busy_o,
                  output frames_sent_o, output frames_dropped_o);
`else
  modport master (output tx_data_i, output tx_ctrl_i,
                  input gmii_txd_o, input gmii_tx_en_o, input drop_o, input busy_o);
  modport slave  (input tx_data_i, input tx_ctrl_i,
                  output gmii_txd_o, output gmii_tx_en_o, output drop_o, output busy_o);
`endif

endinterface

// File: rtl/tx_frame_framer_buffer.sv
// Store-and-forward frame buffer: one-byte staging register, {eof,data}
// memory and wr/commit/rd pointers. An overflowing frame is rewound to the
// last commit point, so committed frames are never disturbed.
module tx_frame_buffer
  import switch_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 11
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] in_data,
  input  logic       in_ctrl,
  input  logic       rd_inc,
  output buf_entry_t rd_entry,
  output logic       frame_avail,
  output logic       full,
  output logic       wr_req
);

  localparam int C_DEPTH = 2 ** P_ADDR_WIDTH;
  localparam logic [P_ADDR_WIDTH:0] C_FULL_DIST = {1'b1, {P_ADDR_WIDTH{1'b0}}};
  localparam logic [P_ADDR_WIDTH:0] C_PTR_ONE   = {{P_ADDR_WIDTH{1'b0}}, 1'b1};

  buf_entry_t            mem_r [C_DEPTH];
  logic [P_ADDR_WIDTH:0] wr_ptr_r;
  logic [P_ADDR_WIDTH:0] commit_ptr_r;
  logic [P_ADDR_WIDTH:0] rd_ptr_r;
  logic [7:0]            stage_data_r;
  logic                  stage_vld_r;
  logic                  discard_r;
  logic                  full_s;
  logic                  ovf_s;
  logic                  wr_en_s;
  buf_entry_t            wr_entry_s;

  // A staged byte is written every cycle it is valid; the low cycle after a run marks it as eof.
  always_comb begin
    full_s          = ((wr_ptr_r - rd_ptr_r) == C_FULL_DIST);
    ovf_s           = stage_vld_r & full_s;
    wr_en_s         = stage_vld_r & ~full_s;
    wr_entry_s.eof  = ~in_ctrl;
    wr_entry_s.data = stage_data_r;
  end

  // Pointer update: advance on write, commit on eof, rewind to commit point on overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r     <= {(P_ADDR_WIDTH + 1){1'b0}};
      commit_ptr_r <= {(P_ADDR_WIDTH + 1){1'b0}};
      rd_ptr_r     <= {(P_ADDR_WIDTH + 1){1'b0}};
    end else begin
      if (ovf_s) begin
        wr_ptr_r <= commit_ptr_r;
      end else if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + C_PTR_ONE;
        if (wr_entry_s.eof) begin
          commit_ptr_r <= wr_ptr_r + C_PTR_ONE;
        end else begin
          commit_ptr_r <= commit_ptr_r;
        end
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_inc) begin
        rd_ptr_r <= rd_ptr_r + C_PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Staging register and discard flag; discard holds off a frame until its trailing low cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_data_r <= 8'h00;
      stage_vld_r  <= 1'b0;
      discard_r    <= 1'b1;
    end else begin
      if (in_ctrl && !discard_r && !ovf_s) begin
        stage_data_r <= in_data;
        stage_vld_r  <= 1'b1;
      end else begin
        stage_vld_r  <= 1'b0;
      end
      if (!in_ctrl) begin
        discard_r <= 1'b0;
      end else if (ovf_s) begin
        discard_r <= 1'b1;
      end else begin
        discard_r <= discard_r;
      end
    end
  end

  // Frame memory write port (contents need no reset: only committed entries are read).
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[P_ADDR_WIDTH-1:0]] <= wr_entry_s;
    end
  end

  assign rd_entry    = mem_r[rd_ptr_r[P_ADDR_WIDTH-1:0]];
  assign frame_avail = (commit_ptr_r != rd_ptr_r);
  assign full        = full_s;
  assign wr_req      = stage_vld_r;

endmodule

// File: rtl/tx_frame_framer.sv
// Per-port egress framer: buffers whole frames from the crossbar and sends
// them on a GMII-style byte interface with preamble, SFD and inter-frame gap.
// Optional macro TX_FRAMER_STATS_EN adds saturating sent/dropped frame counters.
module tx_frame_framer
  import switch_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 11,
  parameter int P_IFG_BYTES  = 12
) (
  input logic              clk_i,
  input logic              rst_i,
  tx_frame_framer_if.slave bus
);

  localparam int C_IFG_W = (P_IFG_BYTES > 1) ? $clog2(P_IFG_BYTES) : 1;
  localparam logic [C_IFG_W-1:0] C_IFG_LAST = C_IFG_W'(P_IFG_BYTES - 1);
  localparam logic [C_IFG_W-1:0] C_IFG_ONE  = C_IFG_W'(1);

  tx_state_e          state_r, state_n;
  logic [2:0]         pre_cnt_r, pre_cnt_n;
  logic [C_IFG_W-1:0] ifg_cnt_r, ifg_cnt_n;
  logic               last_r, last_n;
  logic [7:0]         txd_r, txd_n;
  logic               tx_en_r, tx_en_n;
  logic               drop_r;
  logic               busy_r;
  logic               rd_inc_s;
  logic               sent_s;
  logic               frame_avail_s;
  logic               full_s;
  logic               wr_req_s;
  logic               drop_s;
  buf_entry_t         rd_entry_s;

  tx_frame_buffer #(.P_ADDR_WIDTH(P_ADDR_WIDTH)) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data     (bus.tx_data_i),
    .in_ctrl     (bus.tx_ctrl_i),
    .rd_inc      (rd_inc_s),
    .rd_entry    (rd_entry_s),
    .frame_avail (frame_avail_s),
    .full        (full_s),
    .wr_req      (wr_req_s)
  );

  assign drop_s = wr_req_s & full_s;

  // Next state and the output byte for the state being entered, so outputs stay registered.
  always_comb begin
    state_n   = state_r;
    pre_cnt_n = pre_cnt_r;
    ifg_cnt_n = ifg_cnt_r;
    last_n    = last_r;
    txd_n     = 8'h00;
    tx_en_n   = 1'b0;
    rd_inc_s  = 1'b0;
    sent_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_avail_s) begin
          state_n   = PRE;
          pre_cnt_n = 3'd0;
          txd_n     = C_PREAMBLE_BYTE;
          tx_en_n   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      PRE: begin
        tx_en_n = 1'b1;
        if (pre_cnt_r == (C_PREAMBLE_LEN - 3'd1)) begin
          state_n = SFD;
          txd_n   = C_SFD_BYTE;
        end else begin
          pre_cnt_n = pre_cnt_r + 3'd1;
          txd_n     = C_PREAMBLE_BYTE;
        end
      end
      SFD: begin
        state_n  = DATA;
        tx_en_n  = 1'b1;
        txd_n    = rd_entry_s.data;
        last_n   = rd_entry_s.eof;
        rd_inc_s = 1'b1;
      end
      DATA: begin
        if (last_r) begin
          state_n   = IFG;
          ifg_cnt_n = {C_IFG_W{1'b0}};
          sent_s    = 1'b1;
        end else begin
          tx_en_n  = 1'b1;
          txd_n    = rd_entry_s.data;
          last_n   = rd_entry_s.eof;
          rd_inc_s = 1'b1;
        end
      end
      IFG: begin
        if (ifg_cnt_r != C_IFG_LAST) begin
          ifg_cnt_n = ifg_cnt_r + C_IFG_ONE;
        end else if (frame_avail_s) begin
          state_n   = PRE;
          pre_cnt_n = 3'd0;
          txd_n     = C_PREAMBLE_BYTE;
          tx_en_n   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state, counters and registered GMII/status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      pre_cnt_r <= 3'd0;
      ifg_cnt_r <= {C_IFG_W{1'b0}};
      last_r    <= 1'b0;
      txd_r     <= 8'h00;
      tx_en_r   <= 1'b0;
      drop_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      pre_cnt_r <= pre_cnt_n;
      ifg_cnt_r <= ifg_cnt_n;
      last_r    <= last_n;
      txd_r     <= txd_n;
      tx_en_r   <= tx_en_n;
      drop_r    <= drop_s;
      busy_r    <= (state_n != IDLE) | frame_avail_s;
    end
  end

  assign bus.gmii_txd_o   = txd_r;
  assign bus.gmii_tx_en_o = tx_en_r;
  assign bus.drop_o       = drop_r;
  assign bus.busy_o       = busy_r;

`ifdef TX_FRAMER_STATS_EN
  logic [31:0] sent_cnt_r;
  logic [31:0] drop_cnt_r;

  // Saturating counters of transmitted and dropped frames.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sent_cnt_r <= 32'd0;
      drop_cnt_r <= 32'd0;
    end else begin
      if (sent_s && (sent_cnt_r != 32'hFFFF_FFFF)) begin
        sent_cnt_r <= sent_cnt_r + 32'd1;
      end else begin
        sent_cnt_r <= sent_cnt_r;
      end
      if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign bus.frames_sent_o    = sent_cnt_r;
  assign bus.frames_dropped_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_tx_frame_framer.sv
// Directed bench: dut_a uses the default 2 KiB buffer, dut_b a 64-byte buffer
// for the overflow cases. Monitors collect transmitted bytes and edge timing.
module tb_tx_frame_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   last_low = 0;

  always #5 clk = ~clk;

  tx_frame_framer_if ifa ();
  tx_frame_framer_if ifb ();

  tx_frame_framer dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  tx_frame_framer #(.P_ADDR_WIDTH(6)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int rise_a[$];
  int fall_a[$];
  int drops_a = 0;
  int drops_b = 0;
  bit prev_en_a = 1'b0;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for dut_a.
  always @(negedge clk) begin
    if (ifa.gmii_tx_en_o === 1'b1) qa.push_back(ifa.gmii_txd_o);
    if ((ifa.gmii_tx_en_o === 1'b1) && !prev_en_a) rise_a.push_back(cyc);
    if ((ifa.gmii_tx_en_o !== 1'b1) && prev_en_a) fall_a.push_back(cyc);
    if (ifa.drop_o === 1'b1) drops_a <= drops_a + 1;
    prev_en_a <= (ifa.gmii_tx_en_o === 1'b1);
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (ifb.gmii_tx_en_o === 1'b1) qb.push_back(ifb.gmii_txd_o);
    if (ifb.drop_o === 1'b1) drops_b <= drops_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic c, input logic [7:0] d);
    if (sel == 0) begin
      ifa.tx_ctrl_i = c;
      ifa.tx_data_i = d;
    end else begin
      ifb.tx_ctrl_i = c;
      ifb.tx_data_i = d;
    end
  endtask

  // Frame of len bytes start, start+1, ... followed by one low cycle.
  task automatic send_frame(input int sel, input int len, input logic [7:0] start);
    for (int i = 0; i < len; i++) begin
      drive(sel, 1'b1, start + 8'(i));
      step();
    end
    drive(sel, 1'b0, 8'h00);
    last_low = cyc;
    step();
  endtask

  task automatic wait_quiet(input int sel);
    bit done;
    done = 1'b0;
    repeat (4) step();
    for (int n = 0; n < 3000 && !done; n++) begin
      if (sel == 0) done = (ifa.busy_o === 1'b0) && (ifa.gmii_tx_en_o === 1'b0);
      else          done = (ifb.busy_o === 1'b0) && (ifb.gmii_tx_en_o === 1'b0);
      if (!done) step();
    end
    if (!done) check("quiet_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic check_frame(input string tag, input logic [7:0] q[$], input int off,
                             input int len, input logic [7:0] start);
    logic [7:0] exp_b;
    logic [7:0] obs_b;
    for (int i = 0; i < len + 8; i++) begin
      if (i < 7)       exp_b = 8'h55;
      else if (i == 7) exp_b = 8'hD5;
      else             exp_b = start + 8'(i - 8);
      obs_b = (off + i < q.size()) ? q[off + i] : 8'hxx;
      check($sformatf("%s[%0d]", tag, i), {24'd0, obs_b}, {24'd0, exp_b});
    end
  endtask

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) step();
    check("rst_txd_a", {24'd0, ifa.gmii_txd_o}, 32'h00);
    check("rst_en_a", {31'd0, ifa.gmii_tx_en_o}, 32'd0);
    check("rst_drop_a", {31'd0, ifa.drop_o}, 32'd0);
    check("rst_busy_a", {31'd0, ifa.busy_o}, 32'd0);
    check("rst_en_b", {31'd0, ifb.gmii_tx_en_o}, 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Single 64-byte frame: latency, content, busy.
    qa.delete(); rise_a.delete(); fall_a.delete();
    send_frame(0, 64, 8'h00);
    repeat (3) step();
    check("busy_during_frame", {31'd0, ifa.busy_o}, 32'd1);
    wait_quiet(0);
    check("latency_low_to_en", 32'(rise_a[0] - last_low), 32'd2);
    check("len_64", 32'(qa.size()), 32'd72);
    check_frame("f64", qa, 0, 64, 8'h00);
    check("idle_txd", {24'd0, ifa.gmii_txd_o}, 32'h00);

    // Minimum 1-byte frame.
    qa.delete();
    send_frame(0, 1, 8'hA5);
    wait_quiet(0);
    check("len_1", 32'(qa.size()), 32'd9);
    check_frame("f1", qa, 0, 1, 8'hA5);

    // Two 60-byte frames with a one-cycle gap: exactly 12 idle cycles between them.
    qa.delete(); rise_a.delete(); fall_a.delete();
    send_frame(0, 60, 8'h40);
    send_frame(0, 60, 8'h80);
    wait_quiet(0);
    check("b2b_len", 32'(qa.size()), 32'd136);
    check("b2b_ifg", 32'(rise_a[1] - fall_a[0]), 32'd12);
    check_frame("b2b_f0", qa, 0, 60, 8'h40);
    check_frame("b2b_f1", qa, 68, 60, 8'h80);
    check("drops_a_none", 32'(drops_a), 32'd0);

    // 64-byte buffer: 100-byte frame dropped, then 10-byte and exactly-full 64-byte frames pass.
    qb.delete();
    send_frame(1, 100, 8'h10);
    wait_quiet(1);
    check("ovf_drop_once", 32'(drops_b), 32'd1);
    check("ovf_nothing_sent", 32'(qb.size()), 32'd0);
    send_frame(1, 10, 8'h20);
    wait_quiet(1);
    check_frame("after_ovf", qb, 0, 10, 8'h20);
    qb.delete();
    send_frame(1, 64, 8'hC0);
    wait_quiet(1);
    check("fit64_len", 32'(qb.size()), 32'd72);
    check("fit64_nodrop", 32'(drops_b), 32'd1);
    check_frame("fit64", qb, 0, 64, 8'hC0);

    // Overflowing frame arriving behind a committed 40-byte frame.
    qb.delete();
    send_frame(1, 40, 8'h60);
    send_frame(1, 100, 8'h90);
    wait_quiet(1);
    check("pend_drop", 32'(drops_b), 32'd2);
    check("pend_len", 32'(qb.size()), 32'd48);
    check_frame("pend_f", qb, 0, 40, 8'h60);
    qb.delete();
    send_frame(1, 10, 8'h33);
    wait_quiet(1);
    check("post_pend_len", 32'(qb.size()), 32'd18);
    check_frame("post_pend", qb, 0, 10, 8'h33);

    // Reset mid-DATA; frame in progress at release is discarded silently.
    send_frame(0, 64, 8'h00);
    repeat (20) step();
    check("pre_rst_en", {31'd0, ifa.gmii_tx_en_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_en", {31'd0, ifa.gmii_tx_en_o}, 32'd0);
    check("rst_async_txd", {24'd0, ifa.gmii_txd_o}, 32'h00);
    drive(0, 1'b1, 8'hEE);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 8'hE0 + 8'(i));
      step();
    end
    drive(0, 1'b0, 8'h00);
    step();
    qa.delete();
    repeat (15) step();
    check("partial_not_sent", 32'(qa.size()), 32'd0);
    check("partial_no_drop", 32'(drops_a), 32'd0);
    send_frame(0, 8, 8'h70);
    wait_quiet(0);
    check("clean_len", 32'(qa.size()), 32'd16);
    check_frame("clean", qa, 0, 8, 8'h70);

`ifdef TX_FRAMER_STATS_EN
    // Counters: dut_b was reset above; 3 good frames and 1 oversize.
    send_frame(1, 10, 8'h01);
    wait_quiet(1);
    send_frame(1, 12, 8'h02);
    wait_quiet(1);
    send_frame(1, 5, 8'h03);
    wait_quiet(1);
    send_frame(1, 100, 8'h04);
    wait_quiet(1);
    check("stats_sent", ifb.frames_sent_o, 32'd3);
    check("stats_dropped", ifb.frames_dropped_o, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
